wb_xfer_ctrl: RTL and testbench
===============================

WB_XFER_CTRL -- requirements
Module: wb_xfer_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, meaning the number of wbs_cyc_o-high cycles before an unanswered transfer is aborted (legal range 2..65535).
REQ-002 SHALL have parameter TO_BITS, default `LOG2(TIMEOUT-1)+1, meaning the timer width.
REQ-003 SHALL have port wb_clk_i, in, 1, the single clock; all logic on its rising edge.
REQ-004 SHALL have port wb_rst_i, in, 1, asynchronous active-high reset.
REQ-005 SHALL have ports wbm_cyc_i, wbm_stb_i, wbm_we_i, in, 1 each, the upstream request from the master arbiter (single-cycle strobe accepted).
REQ-006 SHALL have ports wbm_sel_i, in, 2, and wbm_adr_i, in, 32, the upstream byte select and address.
REQ-007 SHALL have ports wbm_dat_i, in, 16, the write data, and wbm_dat_o, out, 16, the registered read data.
REQ-008 SHALL have ports wbm_ack_o and wbm_err_o, out, 1 each, the upstream one-cycle response pulses.
REQ-009 SHALL have ports wbs_cyc_o, wbs_stb_o, wbs_we_o, out, 1 each; wbs_sel_o, out, 2; wbs_adr_o, out, 32; wbs_dat_o, out, 16 (downstream slave bus).
REQ-010 SHALL have ports wbs_dat_i, in, 16, and wbs_ack_i, wbs_err_i, in, 1 each (downstream response).
REQ-011 SHALL have ports timeout_o, out, 1, a one-cycle abort pulse; overrun_o, out, 1, a one-cycle pulse marking a dropped request; to_count_o, out, 16, the saturating abort count; to_adr_o, out, 32, the address of the last aborted transfer.

Function
REQ-012 SHALL implement FSM IDLE -> BUSY -> DONE -> IDLE.
REQ-013 IDLE: on an edge with wbm_cyc_i & wbm_stb_i, SHALL latch we/sel/adr/dat, clear the timer, and enter BUSY.
REQ-014 SHALL drive wbs_cyc_o = wbs_stb_o = 1 for exactly the cycles spent in BUSY, with the first cycle following the request edge (1-cycle latency).
REQ-015 wbs_we_o/sel_o/adr_o/dat_o SHALL present the latched values, stable for the whole of BUSY.
REQ-016 BUSY, wbs_ack_i sampled high: SHALL register wbs_dat_i into wbm_dat_o, pulse wbm_ack_o on the next cycle, drop wbs_cyc_o, and enter DONE.
REQ-017 BUSY, wbs_err_i sampled high: SHALL pulse wbm_err_o on the next cycle, leave wbm_dat_o unchanged, and enter DONE; err wins when ack and err arrive together.
REQ-018 BUSY, neither asserted: the timer SHALL increment; on the edge where timer == TIMEOUT-1, the block SHALL pulse wbm_err_o and timeout_o, capture the latched address into to_adr_o, increment to_count_o (saturating at 0xFFFF), and enter DONE.
REQ-019 ack/err on the timeout edge SHALL take priority over timeout (normal completion, no timeout_o).
REQ-020 DONE SHALL last exactly one cycle, with wbs_cyc_o low.
REQ-021 A request sampled in BUSY or DONE SHALL be dropped and pulse overrun_o on the next cycle; it SHALL NOT be queued.
REQ-022 wbm_ack_o, wbm_err_o, timeout_o and overrun_o SHALL each be high for at most one cycle per event; ack and err SHALL never both be high.
REQ-023 wbs_ack_i and wbs_err_i outside BUSY SHALL be ignored.

Reset
REQ-024 On wb_rst_i high, the block SHALL asynchronously enter IDLE and zero every output, the timer and all latched registers.
REQ-025 Reset asserted during BUSY SHALL drop wbs_cyc_o immediately, with no response pulse generated.
REQ-026 The first request SHALL be accepted on the first clock edge after reset deassertion.

Structure
REQ-027 FSM state encodings SHALL live in a shared include (wb_xfer_ctrl_defs.v) alongside the existing log2.v.
REQ-028 Timer and timeout compare SHALL be one sub-module, wb_xfer_timer (clear, enable, expired output), parameterised by TIMEOUT.
REQ-029 All outputs SHALL be registered; no combinational path from any wbs_* input to any wbm_* output.

Verification
REQ-030 Read: request adr=0x00001234, slave acks 3 cycles after cyc rises with dat=0xBEEF -> wbs_cyc_o high 3 cycles, wbm_ack_o one cycle later, wbm_dat_o=0xBEEF.
REQ-031 Write: we=1, sel=2'b01, dat=0x00A5, immediate ack -> wbs_* outputs match for 1 cycle, wbm_ack_o pulse, wbm_dat_o unchanged.
REQ-032 Timeout with TIMEOUT=8 and a silent slave -> wbs_cyc_o high exactly 8 cycles, then wbm_err_o and timeout_o pulse, to_count_o 0->1, to_adr_o = request address.
REQ-033 ack and err together -> wbm_err_o only; ack on cycle 8 with TIMEOUT=8 -> wbm_ack_o, no timeout_o.
REQ-034 Second strobe during BUSY -> overrun_o pulse, no second downstream cycle.
REQ-035 Reset during BUSY -> wbs_cyc_o low without waiting for a clock, no ack/err; a new request after release completes normally.

Source files
------------

// File: rtl/wb_xfer_ctrl_pkg.sv
// Shared types and constants for the single-outstanding Wishbone transfer controller.
package wb_xfer_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } xfer_state_e;

  localparam int unsigned ADR_W = 32;
  localparam int unsigned DAT_W = 16;
  localparam int unsigned SEL_W = 2;
  localparam int unsigned CNT_W = 16;

  localparam logic [CNT_W-1:0] TO_COUNT_MAX = '1;

  // Width needed to hold TIMEOUT-1, i.e. floor(log2(TIMEOUT-1))+1 for TIMEOUT >= 2.
  function automatic int unsigned to_bits_f(input int unsigned timeout);
    int unsigned w;
    w = $clog2(timeout);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/wb_xfer_timer.sv
// Up-counting transfer timer; expired_o flags the cycle whose count equals TIMEOUT-1.
module wb_xfer_timer
  import wb_xfer_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned TO_BITS = to_bits_f(TIMEOUT)
) (
  input  logic wb_clk_i,
  input  logic wb_rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam logic [TO_BITS-1:0] TERM = TO_BITS'(TIMEOUT - 1);

  logic [TO_BITS-1:0] cnt_q;
  logic [TO_BITS-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != TERM)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == TERM);

endmodule

// File: rtl/wb_xfer_ctrl.sv
// Wishbone transfer controller: forwards one upstream request at a time to the slave bus,
// returns the response and aborts transfers the slave never answers.
module wb_xfer_ctrl
  import wb_xfer_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned TO_BITS = to_bits_f(TIMEOUT)
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,

  input  logic             wbm_cyc_i,
  input  logic             wbm_stb_i,
  input  logic             wbm_we_i,
  input  logic [SEL_W-1:0] wbm_sel_i,
  input  logic [ADR_W-1:0] wbm_adr_i,
  input  logic [DAT_W-1:0] wbm_dat_i,
  output logic [DAT_W-1:0] wbm_dat_o,
  output logic             wbm_ack_o,
  output logic             wbm_err_o,

  output logic             wbs_cyc_o,
  output logic             wbs_stb_o,
  output logic             wbs_we_o,
  output logic [SEL_W-1:0] wbs_sel_o,
  output logic [ADR_W-1:0] wbs_adr_o,
  output logic [DAT_W-1:0] wbs_dat_o,
  input  logic [DAT_W-1:0] wbs_dat_i,
  input  logic             wbs_ack_i,
  input  logic             wbs_err_i,

  output logic             timeout_o,
  output logic             overrun_o,
  output logic [CNT_W-1:0] to_count_o,
  output logic [ADR_W-1:0] to_adr_o
);

  // state | meaning
  // IDLE  | waiting for an upstream strobe
  // BUSY  | downstream cycle open, waiting for ack/err or timer expiry
  // DONE  | one-cycle gap while the upstream response pulse is visible

  xfer_state_e state_q, state_d;

  logic             cyc_q, cyc_d;
  logic             ack_q, ack_d;
  logic             err_q, err_d;
  logic             to_q, to_d;
  logic             ovr_q, ovr_d;
  logic             we_q, we_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [ADR_W-1:0] adr_q, adr_d;
  logic [DAT_W-1:0] wdat_q, wdat_d;
  logic [DAT_W-1:0] rdat_q, rdat_d;
  logic [CNT_W-1:0] to_cnt_q, to_cnt_d;
  logic [ADR_W-1:0] to_adr_q, to_adr_d;

  logic req;
  logic tmr_clr;
  logic tmr_en;
  logic tmr_expired;

  assign req = wbm_cyc_i & wbm_stb_i;

  wb_xfer_timer #(
    .TIMEOUT (TIMEOUT),
    .TO_BITS (TO_BITS)
  ) u_timer (
    .wb_clk_i  (wb_clk_i),
    .wb_rst_i  (wb_rst_i),
    .clr_i     (tmr_clr),
    .en_i      (tmr_en),
    .expired_o (tmr_expired)
  );

  always_comb begin
    state_d  = state_q;
    cyc_d    = 1'b0;
    ack_d    = 1'b0;
    err_d    = 1'b0;
    to_d     = 1'b0;
    ovr_d    = 1'b0;
    we_d     = we_q;
    sel_d    = sel_q;
    adr_d    = adr_q;
    wdat_d   = wdat_q;
    rdat_d   = rdat_q;
    to_cnt_d = to_cnt_q;
    to_adr_d = to_adr_q;
    tmr_clr  = 1'b0;
    tmr_en   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (req) begin
          we_d    = wbm_we_i;
          sel_d   = wbm_sel_i;
          adr_d   = wbm_adr_i;
          wdat_d  = wbm_dat_i;
          tmr_clr = 1'b1;
          cyc_d   = 1'b1;
          state_d = ST_BUSY;
        end
      end

      ST_BUSY: begin
        ovr_d = req;
        // Slave responses beat the timer on the expiry edge; err beats ack.
        if (wbs_err_i) begin
          err_d   = 1'b1;
          state_d = ST_DONE;
        end else if (wbs_ack_i) begin
          ack_d   = 1'b1;
          if (!we_q) begin
            rdat_d = wbs_dat_i;
          end
          state_d = ST_DONE;
        end else if (tmr_expired) begin
          err_d    = 1'b1;
          to_d     = 1'b1;
          to_adr_d = adr_q;
          to_cnt_d = (to_cnt_q == TO_COUNT_MAX) ? to_cnt_q : to_cnt_q + 1'b1;
          state_d  = ST_DONE;
        end else begin
          tmr_en = 1'b1;
          cyc_d  = 1'b1;
        end
      end

      ST_DONE: begin
        ovr_d   = req;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q  <= ST_IDLE;
      cyc_q    <= 1'b0;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
      to_q     <= 1'b0;
      ovr_q    <= 1'b0;
      we_q     <= 1'b0;
      sel_q    <= '0;
      adr_q    <= '0;
      wdat_q   <= '0;
      rdat_q   <= '0;
      to_cnt_q <= '0;
      to_adr_q <= '0;
    end else begin
      state_q  <= state_d;
      cyc_q    <= cyc_d;
      ack_q    <= ack_d;
      err_q    <= err_d;
      to_q     <= to_d;
      ovr_q    <= ovr_d;
      we_q     <= we_d;
      sel_q    <= sel_d;
      adr_q    <= adr_d;
      wdat_q   <= wdat_d;
      rdat_q   <= rdat_d;
      to_cnt_q <= to_cnt_d;
      to_adr_q <= to_adr_d;
    end
  end

  // cyc_q mirrors "next state is BUSY" so the bus strobe comes straight from a flop.
  assign wbs_cyc_o  = cyc_q;
  assign wbs_stb_o  = cyc_q;
  assign wbs_we_o   = we_q;
  assign wbs_sel_o  = sel_q;
  assign wbs_adr_o  = adr_q;
  assign wbs_dat_o  = wdat_q;

  assign wbm_dat_o  = rdat_q;
  assign wbm_ack_o  = ack_q;
  assign wbm_err_o  = err_q;

  assign timeout_o  = to_q;
  assign overrun_o  = ovr_q;
  assign to_count_o = to_cnt_q;
  assign to_adr_o   = to_adr_q;

endmodule

// File: tb/tb_wb_xfer_ctrl.sv
// Directed bench for wb_xfer_ctrl with TIMEOUT=8.
module tb_wb_xfer_ctrl;

  logic        wb_clk_i;
  logic        wb_rst_i;
  logic        wbm_cyc_i;
  logic        wbm_stb_i;
  logic        wbm_we_i;
  logic [1:0]  wbm_sel_i;
  logic [31:0] wbm_adr_i;
  logic [15:0] wbm_dat_i;
  logic [15:0] wbm_dat_o;
  logic        wbm_ack_o;
  logic        wbm_err_o;
  logic        wbs_cyc_o;
  logic        wbs_stb_o;
  logic        wbs_we_o;
  logic [1:0]  wbs_sel_o;
  logic [31:0] wbs_adr_o;
  logic [15:0] wbs_dat_o;
  logic [15:0] wbs_dat_i;
  logic        wbs_ack_i;
  logic        wbs_err_i;
  logic        timeout_o;
  logic        overrun_o;
  logic [15:0] to_count_o;
  logic [31:0] to_adr_o;

  int checks = 0;
  int errors = 0;

  wb_xfer_ctrl #(.TIMEOUT(8)) dut (
    .wb_clk_i   (wb_clk_i),
    .wb_rst_i   (wb_rst_i),
    .wbm_cyc_i  (wbm_cyc_i),
    .wbm_stb_i  (wbm_stb_i),
    .wbm_we_i   (wbm_we_i),
    .wbm_sel_i  (wbm_sel_i),
    .wbm_adr_i  (wbm_adr_i),
    .wbm_dat_i  (wbm_dat_i),
    .wbm_dat_o  (wbm_dat_o),
    .wbm_ack_o  (wbm_ack_o),
    .wbm_err_o  (wbm_err_o),
    .wbs_cyc_o  (wbs_cyc_o),
    .wbs_stb_o  (wbs_stb_o),
    .wbs_we_o   (wbs_we_o),
    .wbs_sel_o  (wbs_sel_o),
    .wbs_adr_o  (wbs_adr_o),
    .wbs_dat_o  (wbs_dat_o),
    .wbs_dat_i  (wbs_dat_i),
    .wbs_ack_i  (wbs_ack_i),
    .wbs_err_i  (wbs_err_i),
    .timeout_o  (timeout_o),
    .overrun_o  (overrun_o),
    .to_count_o (to_count_o),
    .to_adr_o   (to_adr_o)
  );

  initial wb_clk_i = 1'b0;
  always #5 wb_clk_i = ~wb_clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge wb_clk_i);
    #1;
  endtask

  task automatic request(input logic we, input logic [1:0] sel, input logic [31:0] adr,
                         input logic [15:0] dat);
    wbm_cyc_i = 1'b1;
    wbm_stb_i = 1'b1;
    wbm_we_i  = we;
    wbm_sel_i = sel;
    wbm_adr_i = adr;
    wbm_dat_i = dat;
  endtask

  task automatic drop_req();
    wbm_cyc_i = 1'b0;
    wbm_stb_i = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    wb_rst_i  = 1'b1;
    wbm_cyc_i = 1'b0;
    wbm_stb_i = 1'b0;
    wbm_we_i  = 1'b0;
    wbm_sel_i = 2'b00;
    wbm_adr_i = 32'h0;
    wbm_dat_i = 16'h0;
    wbs_dat_i = 16'h0;
    wbs_ack_i = 1'b0;
    wbs_err_i = 1'b0;

    #3;
    check("rst_cyc", {31'd0, wbs_cyc_o}, 32'd0);
    check("rst_ack_err", {30'd0, wbm_ack_o, wbm_err_o}, 32'd0);
    check("rst_to_count", {16'd0, to_count_o}, 32'd0);
    check("rst_dat_o", {16'd0, wbm_dat_o}, 32'd0);

    // Read, acked on the 3rd bus cycle; request present right at reset release.
    #9;
    wb_rst_i = 1'b0;
    request(1'b0, 2'b11, 32'h0000_1234, 16'h0);
    tick();
    drop_req();
    check("rd_cyc1", {31'd0, wbs_cyc_o}, 32'd1);
    check("rd_stb1", {31'd0, wbs_stb_o}, 32'd1);
    check("rd_adr", wbs_adr_o, 32'h0000_1234);
    check("rd_we", {31'd0, wbs_we_o}, 32'd0);
    tick();
    check("rd_cyc2", {31'd0, wbs_cyc_o}, 32'd1);
    tick();
    check("rd_cyc3", {31'd0, wbs_cyc_o}, 32'd1);
    wbs_ack_i = 1'b1;
    wbs_dat_i = 16'hBEEF;
    tick();
    wbs_ack_i = 1'b0;
    check("rd_cyc_done", {31'd0, wbs_cyc_o}, 32'd0);
    check("rd_ack", {31'd0, wbm_ack_o}, 32'd1);
    check("rd_err", {31'd0, wbm_err_o}, 32'd0);
    check("rd_dat", {16'd0, wbm_dat_o}, 32'h0000_BEEF);
    tick();
    check("rd_ack_pulse", {31'd0, wbm_ack_o}, 32'd0);

    // Write with immediate ack; read data register must keep 0xBEEF.
    request(1'b1, 2'b01, 32'h0000_0020, 16'h00A5);
    tick();
    drop_req();
    check("wr_cyc", {31'd0, wbs_cyc_o}, 32'd1);
    check("wr_we", {31'd0, wbs_we_o}, 32'd1);
    check("wr_sel", {30'd0, wbs_sel_o}, 32'd1);
    check("wr_dat", {16'd0, wbs_dat_o}, 32'h0000_00A5);
    check("wr_adr", wbs_adr_o, 32'h0000_0020);
    wbs_ack_i = 1'b1;
    wbs_dat_i = 16'h1111;
    tick();
    wbs_ack_i = 1'b0;
    check("wr_cyc_done", {31'd0, wbs_cyc_o}, 32'd0);
    check("wr_ack", {31'd0, wbm_ack_o}, 32'd1);
    check("wr_dat_keep", {16'd0, wbm_dat_o}, 32'h0000_BEEF);
    tick();

    // Stray slave responses in IDLE are ignored.
    wbs_ack_i = 1'b1;
    wbs_err_i = 1'b1;
    tick();
    wbs_ack_i = 1'b0;
    wbs_err_i = 1'b0;
    check("idle_ign", {29'd0, wbm_ack_o, wbm_err_o, wbs_cyc_o}, 32'd0);

    // Silent slave: 8 bus cycles then abort.
    request(1'b0, 2'b11, 32'hCAFE_0000, 16'h0);
    tick();
    drop_req();
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (!wbs_cyc_o) break;
      n++;
      tick();
    end
    check("to_cyc_len", n, 32'd8);
    check("to_err", {31'd0, wbm_err_o}, 32'd1);
    check("to_pulse", {31'd0, timeout_o}, 32'd1);
    check("to_ack", {31'd0, wbm_ack_o}, 32'd0);
    check("to_count", {16'd0, to_count_o}, 32'd1);
    check("to_adr", to_adr_o, 32'hCAFE_0000);
    tick();
    check("to_clear", {30'd0, wbm_err_o, timeout_o}, 32'd0);

    // ack and err together: err only.
    request(1'b0, 2'b11, 32'h0000_0040, 16'h0);
    tick();
    drop_req();
    wbs_ack_i = 1'b1;
    wbs_err_i = 1'b1;
    wbs_dat_i = 16'h7777;
    tick();
    wbs_ack_i = 1'b0;
    wbs_err_i = 1'b0;
    check("ae_err", {31'd0, wbm_err_o}, 32'd1);
    check("ae_ack", {31'd0, wbm_ack_o}, 32'd0);
    check("ae_dat", {16'd0, wbm_dat_o}, 32'h0000_BEEF);
    tick();

    // ack on the 8th cycle beats the timeout.
    request(1'b0, 2'b11, 32'h0000_0080, 16'h0);
    tick();
    drop_req();
    for (int i = 0; i < 7; i++) tick();
    check("a8_cyc", {31'd0, wbs_cyc_o}, 32'd1);
    wbs_ack_i = 1'b1;
    wbs_dat_i = 16'h1357;
    tick();
    wbs_ack_i = 1'b0;
    check("a8_ack", {31'd0, wbm_ack_o}, 32'd1);
    check("a8_no_to", {30'd0, timeout_o, wbm_err_o}, 32'd0);
    check("a8_count", {16'd0, to_count_o}, 32'd1);
    check("a8_dat", {16'd0, wbm_dat_o}, 32'h0000_1357);
    tick();

    // Second strobe while BUSY is dropped with an overrun pulse.
    request(1'b0, 2'b11, 32'h0000_00C0, 16'h0);
    tick();
    wbm_adr_i = 32'h0000_0DD0;
    tick();
    drop_req();
    check("ov_pulse", {31'd0, overrun_o}, 32'd1);
    check("ov_adr", wbs_adr_o, 32'h0000_00C0);
    tick();
    check("ov_pulse_end", {31'd0, overrun_o}, 32'd0);
    wbs_ack_i = 1'b1;
    tick();
    wbs_ack_i = 1'b0;
    check("ov_ack", {31'd0, wbm_ack_o}, 32'd1);
    tick();
    check("ov_no_2nd_a", {31'd0, wbs_cyc_o}, 32'd0);
    tick();
    check("ov_no_2nd_b", {31'd0, wbs_cyc_o}, 32'd0);

    // Reset in BUSY drops the bus without a clock edge; recovery afterwards.
    request(1'b0, 2'b11, 32'h0000_0100, 16'h0);
    tick();
    drop_req();
    check("rb_cyc", {31'd0, wbs_cyc_o}, 32'd1);
    #2;
    wb_rst_i = 1'b1;
    #1;
    check("rb_cyc_drop", {31'd0, wbs_cyc_o}, 32'd0);
    check("rb_count", {16'd0, to_count_o}, 32'd0);
    tick();
    check("rb_no_resp", {30'd0, wbm_ack_o, wbm_err_o}, 32'd0);
    wb_rst_i = 1'b0;
    request(1'b0, 2'b10, 32'h0000_0200, 16'h0);
    tick();
    drop_req();
    check("rb_new_cyc", {31'd0, wbs_cyc_o}, 32'd1);
    check("rb_new_adr", wbs_adr_o, 32'h0000_0200);
    wbs_ack_i = 1'b1;
    wbs_dat_i = 16'h5A5A;
    tick();
    wbs_ack_i = 1'b0;
    check("rb_new_ack", {31'd0, wbm_ack_o}, 32'd1);
    check("rb_new_dat", {16'd0, wbm_dat_o}, 32'h0000_5A5A);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
